// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared state encoding and sizing helper for the bit-serial
//               subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The bit counter must be able to hold the operand width itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_sub_fs.sv
`default_nettype none
// ============================================================================
// Module      : fs
// Description : One-bit combinational full subtractor (x - y - bin).
// Revision    : 1.0 - initial release
// ============================================================================
module fs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub
// Description : Bit-serial subtractor, LSB first, one bit per clock.
//               Define SERIAL_SUB_OVF_EN to add the signed overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             bq;
    logic [CW-1:0]    cnt;
    logic             bit_d;
    logic             bit_b;

    fs u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (bq),
        .diff (bit_d),
        .bout (bit_b)
    );

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep a copy.
    logic x_msb;
    logic y_msb;
    logic ovf_next;

    assign ovf_next = (x_msb != y_msb) && (res_sr[WIDTH-1] != x_msb);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bq     <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
            x_msb  <= 1'b0;
            y_msb  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= x;
                        b_sr   <= y;
                        res_sr <= '0;
                        bq     <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        x_msb  <= x[WIDTH-1];
                        y_msb  <= y[WIDTH-1];
`endif
                    end
                end

                RUN: begin
                    // Result fills from the MSB end so it is aligned after WIDTH shifts.
                    res_sr <= {bit_d, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    bq     <= bit_b;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end

                DONE: begin
                    diff   <= res_sr;
                    borrow <= bq;
                    done   <= 1'b1;
                    state  <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf    <= ovf_next;
`endif
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
